// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle control path: opcodes, FSM states,
// immediate formats, instruction classes and the write-back/PC select codes.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5
  } imm_sel_t;

  typedef enum logic [3:0] {
    FMT_R, FMT_ALUI, FMT_LOAD, FMT_STORE, FMT_BRANCH,
    FMT_JAL, FMT_JALR, FMT_LUI, FMT_AUIPC, FMT_ILLEGAL
  } fmt_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

endpackage

// File: rtl/opcode_dec.sv
// Combinational opcode classifier: instruction class, immediate format and
// a legal flag for the control FSM.
module opcode_dec
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] fmt,
  output logic [2:0] imm_sel,
  output logic       legal
);

  always_comb begin
    fmt     = FMT_ILLEGAL;
    imm_sel = IMM_NONE;
    legal   = 1'b1;
    case (opcode)
      OP_R:      fmt = FMT_R;
      OP_IMM:    begin fmt = FMT_ALUI;   imm_sel = IMM_I; end
      OP_LOAD:   begin fmt = FMT_LOAD;   imm_sel = IMM_I; end
      OP_STORE:  begin fmt = FMT_STORE;  imm_sel = IMM_S; end
      OP_BRANCH: begin fmt = FMT_BRANCH; imm_sel = IMM_B; end
      OP_JAL:    begin fmt = FMT_JAL;    imm_sel = IMM_J; end
      OP_JALR:   begin fmt = FMT_JALR;   imm_sel = IMM_I; end
      OP_LUI:    begin fmt = FMT_LUI;    imm_sel = IMM_U; end
      OP_AUIPC:  begin fmt = FMT_AUIPC;  imm_sel = IMM_U; end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// sticky TRAP state and a retired-instruction counter.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_cond,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic [2:0]  imm_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [31:0] retired
);

  state_t      state, state_nxt;
  logic [31:0] retired_q;
  logic [3:0]  fmt;
  logic [2:0]  dec_imm;
  logic        legal;

  opcode_dec u_dec (
    .opcode  (opcode),
    .fmt     (fmt),
    .imm_sel (dec_imm),
    .legal   (legal)
  );

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel      = WB_ALU;
    imm_sel     = IMM_NONE;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    trap        = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        imm_sel   = dec_imm;
        state_nxt = legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        imm_sel     = dec_imm;
        alu_src_imm = !((fmt == FMT_R) || (fmt == FMT_BRANCH));
        if (fmt == FMT_BRANCH) begin
          // a not-taken branch still retires, so the PC advances either way
          pc_we     = 1'b1;
          pc_sel    = br_cond ? PC_IMM : PC_PLUS4;
          state_nxt = ST_FETCH;
        end else if ((fmt == FMT_LOAD) || (fmt == FMT_STORE)) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        imm_sel  = dec_imm;
        dmem_req = 1'b1;
        dmem_we  = (fmt == FMT_STORE);
        if (dmem_ready) begin
          pc_we     = (fmt == FMT_STORE);
          state_nxt = (fmt == FMT_STORE) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        imm_sel   = dec_imm;
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        state_nxt = ST_FETCH;
        case (fmt)
          FMT_LOAD: wb_sel = WB_MEM;
          FMT_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_IMM; end
          FMT_JALR: begin wb_sel = WB_PC4; pc_sel = PC_ALU; end
          FMT_LUI:  wb_sel = WB_IMM;
          default:  wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: trap = 1'b1;
      default: state_nxt = ST_FETCH;
    endcase
    // Reset is synchronous, so the state may still be anywhere; hold every output quiet.
    if (!reset) begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_we      = 1'b0;
      alu_src_imm = 1'b0;
      wb_sel      = WB_ALU;
      imm_sel     = IMM_NONE;
      pc_we       = 1'b0;
      pc_sel      = PC_PLUS4;
      trap        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_FETCH;
      retired_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (pc_we) retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected traces built
// from the instruction class and chosen stall counts, with randomized readies.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        imem_ready, dmem_ready, br_cond;
  logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, alu_src_imm, pc_we, trap;
  logic [1:0]  wb_sel, pc_sel;
  logic [2:0]  imm_sel;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .br_cond     (br_cond),
    .imem_req    (imem_req),
    .ir_we       (ir_we),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .reg_we      (reg_we),
    .alu_src_imm (alu_src_imm),
    .wb_sel      (wb_sel),
    .imm_sel     (imm_sel),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .trap        (trap),
    .retired     (retired)
  );

  typedef struct packed {
    logic       imem_req, ir_we, dmem_req, dmem_we, reg_we, alu_src_imm;
    logic [1:0] wb_sel;
    logic [2:0] imm_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       trap;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_ret = 32'd0;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: return 3'd1;
      7'b0100011:                         return 3'd2;
      7'b1100011:                         return 3'd3;
      7'b0110111, 7'b0010111:             return 3'd4;
      7'b1101111:                         return 3'd5;
      default:                            return 3'd0;
    endcase
  endfunction

  function automatic bit legal_op(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare just after, then advance the model.
  task automatic step(input logic rst_n, input logic [6:0] op, input logic ir, input logic dr,
                      input logic bc, input exp_t e, input string tag);
    exp_t act;
    @(negedge clk);
    reset = rst_n; opcode = op; imem_ready = ir; dmem_ready = dr; br_cond = bc;
    #1;
    act = {imem_req, ir_we, dmem_req, dmem_we, reg_we, alu_src_imm,
           wb_sel, imm_sel, pc_we, pc_sel, trap};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s op=%b outputs actual=%h required=%h", tag, op, act, e);
    end
    check32({tag, "_retired"}, retired, model_ret);
    @(posedge clk);
    if (!rst_n) model_ret = 32'd0;
    else if (e.pc_we) model_ret = model_ret + 32'd1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int istall, input int dstall,
                           input logic br, input bit rst_in_mem, output int ncyc);
    exp_t e;
    logic [2:0] imm;
    bit is_r, is_b, is_ld, is_st, is_jal, is_jalr, is_lui;
    imm = imm_of(op);
    is_r = (op == 7'b0110011); is_b = (op == 7'b1100011);
    is_ld = (op == 7'b0000011); is_st = (op == 7'b0100011);
    is_jal = (op == 7'b1101111); is_jalr = (op == 7'b1100111); is_lui = (op == 7'b0110111);
    ncyc = 0;
    for (int i = 0; i < istall; i++) begin
      e = '0; e.imem_req = 1'b1;
      step(1'b1, rop(), 1'b0, rb(), rb(), e, "fetch_wait"); ncyc++;
    end
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
    step(1'b1, rop(), 1'b1, rb(), rb(), e, "fetch"); ncyc++;
    e = '0; e.imm_sel = imm;
    step(1'b1, op, rb(), rb(), rb(), e, "decode"); ncyc++;
    if (!legal_op(op)) return;
    e = '0; e.imm_sel = imm; e.alu_src_imm = !(is_r || is_b);
    if (is_b) begin e.pc_we = 1'b1; e.pc_sel = br ? 2'b01 : 2'b00; end
    step(1'b1, op, rb(), rb(), is_b ? br : rb(), e, "exec"); ncyc++;
    if (is_b) return;
    if (is_ld || is_st) begin
      e = '0; e.imm_sel = imm; e.dmem_req = 1'b1; e.dmem_we = is_st;
      for (int i = 0; i < dstall; i++) begin
        step(1'b1, op, rb(), 1'b0, rb(), e, "mem_wait"); ncyc++;
      end
      if (rst_in_mem) begin
        step(1'b0, op, rb(), 1'b0, rb(), exp_t'(0), "mem_reset"); ncyc++;
        return;
      end
      e.pc_we = is_st;
      step(1'b1, op, rb(), 1'b1, rb(), e, "mem_done"); ncyc++;
      if (is_st) return;
    end
    e = '0; e.imm_sel = imm; e.reg_we = 1'b1; e.pc_we = 1'b1;
    e.wb_sel = is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
    e.pc_sel = is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
    step(1'b1, op, rb(), rb(), rb(), e, "wb"); ncyc++;
  endtask

  initial begin
    int n;
    exp_t et;
    logic [6:0] op;
    reset = 1'b0; opcode = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0; br_cond = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, rop(), rb(), rb(), rb(), exp_t'(0), "reset_state");

    run_instr(7'b0010011, 0, 0, 1'b0, 1'b0, n);
    #1;
    check32("addi_cycles", 32'(n), 32'd4);
    check32("addi_retired", retired, 32'd1);

    run_instr(7'b0000011, 0, 3, 1'b0, 1'b0, n);
    check32("lw_stall_cycles", 32'(n), 32'd8);

    run_instr(7'b1100011, 0, 0, 1'b1, 1'b0, n);
    check32("beq_taken_cycles", 32'(n), 32'd3);
    run_instr(7'b1100011, 0, 0, 1'b0, 1'b0, n);
    #1;
    check32("beq_nt_cycles", 32'(n), 32'd3);
    check32("retired_after_4", retired, 32'd4);

    run_instr(7'b1111111, 0, 0, 1'b0, 1'b0, n);
    et = '0; et.trap = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, rop(), rb(), rb(), rb(), et, "trap_hold");
    #1;
    check32("trap_retired_frozen", retired, 32'd4);
    step(1'b0, rop(), rb(), rb(), rb(), exp_t'(0), "trap_reset");

    run_instr(7'b0100011, 1, 2, 1'b0, 1'b1, n);
    #1;
    check32("store_reset_retired", retired, 32'd0);

    run_instr(7'b0100011, 0, 0, 1'b0, 1'b0, n);
    check32("sw_cycles", 32'(n), 32'd4);

    #1;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    model_ret = 32'hFFFF_FFFF;
    run_instr(7'b1101111, 0, 0, 1'b0, 1'b0, n);
    #1;
    check32("jal_wrap_retired", retired, 32'd0);
    check32("jal_cycles", 32'(n), 32'd4);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 11) == 0)
        step(1'b0, rop(), rb(), rb(), rb(), exp_t'(0), "rand_reset");
      op = legal_ops[$urandom_range(0, 8)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                ($urandom_range(0, 7) == 0), n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-003 opcode  input  7  inst[6:0] from the instruction register; valid from DECODE onward.
REQ-004 imem_ready  input  1  instruction memory has data for the current request.
REQ-005 dmem_ready  input  1  data memory has completed the current access.
REQ-006 br_cond  input  1  branch comparison result from the ALU; valid in EXEC.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 ir_we  output  1  instruction register load strobe.
REQ-009 dmem_req  output  1  data memory access request.
REQ-010 dmem_we  output  1  data access is a store.
REQ-011 reg_we  output  1  register file write strobe.
REQ-012 alu_src_imm  output  1  ALU operand B = immediate generator output.
REQ-013 wb_sel  output  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
REQ-014 imm_sel  output  3  immediate format to the immediate generator: NONE, I, S, B, U, J.
REQ-015 pc_we  output  1  PC write strobe.
REQ-016 pc_sel  output  2  00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result (JALR, LSB cleared).
REQ-017 trap  output  1  illegal opcode; sticky until reset.
REQ-018 retired  output  32  count of completed instructions.

Function
REQ-019 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-020 FETCH: imem_req=1 and held while imem_ready=0; when imem_ready=1, ir_we=1 for that cycle, then go to DECODE.
REQ-021 DECODE: the opcode is classified; legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 and 0010111; go to EXEC, or to TRAP for any other opcode.
REQ-022 imm_sel SHALL be driven from the opcode in DECODE, EXEC, MEM and WB as follows:
  - I for load, ALU-immediate and JALR
  - S for store; B for branch; U for LUI and AUIPC; J for JAL
  - NONE for R-type and in all other states.
REQ-023 EXEC: alu_src_imm=1 for every format except R-type and branch.
REQ-024 EXEC next state:
  - load or store: MEM
  - branch: FETCH, with pc_we=1 and pc_sel=01 if br_cond=1, otherwise pc_sel=00
  - all other opcodes: WB.
REQ-025 MEM: dmem_req=1, and dmem_we=1 for store; hold until dmem_ready=1.
REQ-026 MEM completion: a load goes to WB; a store goes to FETCH with pc_we=1 and pc_sel=00 in the completing cycle.
REQ-027 WB: reg_we=1 and pc_we=1 for exactly one cycle, then go to FETCH.
REQ-028 WB selects by opcode:
  - load: wb_sel=01
  - JAL: wb_sel=10, pc_sel=01
  - JALR: wb_sel=10, pc_sel=10
  - LUI: wb_sel=11
  - AUIPC and the remaining opcodes: wb_sel=00; pc_sel=00 unless stated above.
REQ-029 Latency with ready inputs tied high:
  - branch: 3 cycles
  - R-type, ALU-immediate, JAL, JALR, LUI, AUIPC and store: 4 cycles
  - load: 5 cycles.
REQ-030 retired SHALL increment by 1 in each cycle where pc_we=1, wrapping from FFFFFFFF to 0.
REQ-031 TRAP: trap=1 and every strobe (imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we) is 0; TRAP is left only through reset.
REQ-032 All outputs SHALL be a function of the state register and the opcode only (Moore-style), except the ready-gated strobes:
  - ir_we
  - MEM-state pc_we
  - EXEC-state pc_we/pc_sel (depends on br_cond).
REQ-033 A ready signal asserted outside its state SHALL be ignored.

Reset
REQ-034 With reset=0 at a rising edge: state=FETCH, retired=0, trap=0.
REQ-035 Reset SHALL take effect in any state, including while a memory request is outstanding.
REQ-036 During reset all strobes SHALL be 0 and the selects 0; imem_req rises the cycle after reset is released.

Structure
REQ-037 The shared package riscv_pkg SHALL hold:
  - opcode localparams
  - the state enum
  - the imm_sel enum (shared with the immediate generator)
  - the wb_sel and pc_sel encodings.
REQ-038 A combinational sub-module opcode_dec SHALL map the opcode to a format class, imm_sel and a legal flag; the FSM SHALL instantiate it.

Verification
REQ-039 ADDI (opcode 0010011), readies high -> states FETCH,DECODE,EXEC,WB; imm_sel=I; reg_we=1 in WB only; retired 0->1.
REQ-040 LW with dmem_ready low for 3 MEM cycles -> dmem_req high for 4 cycles, dmem_we=0, then WB with wb_sel=01; total 8 cycles.
REQ-041 BEQ with br_cond=1 then br_cond=0 -> pc_we=1 in EXEC with pc_sel=01, then pc_sel=00; 3 cycles each; reg_we never 1.
REQ-042 Opcode 1111111 -> TRAP after DECODE; trap=1, no strobes, and retired frozen for 20 cycles; reset=0 returns to FETCH with trap=0.
REQ-043 reset=0 during MEM of a store with dmem_ready=0 -> next cycle state=FETCH, dmem_req=0, retired=0.
REQ-044 retired preloaded to FFFFFFFF via force, then JAL -> retired=0, wb_sel=10, pc_sel=01, imm_sel=J.
